// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Launch/result bundle between an ALU controller (master) and the serial subtractor (slave).
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Cin_msb;
    logic             V;
    logic             Z;
    logic             N;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, Cin_msb, V, Z, N
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, Cin_msb, V, Z, N
    );

endinterface

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full adder cell used as the serial datapath slice.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    always_comb begin
        S    = A ^ B ^ CIN;
        COUT = (A & B) | (A & CIN) | (B & CIN);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first over WIDTH cycles, with start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             c_msb;
    logic             s_bit;
    logic             c_next;
    logic             last;
    logic [WIDTH-1:0] d_final;

    full_adder u_fa (
        .A    (sh_a[0]),
        .B    (sh_b[0]),
        .CIN  (c),
        .S    (s_bit),
        .COUT (c_next)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    assign d_final = {s_bit, res};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN) || (state == DONE);
        bus.done = (state == DONE);
    end

    // Published outputs move only on the final RUN edge; the MSB carry-in is
    // staged in c_msb so a following RUN cannot disturb the visible Cin_msb.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a        <= '0;
            sh_b        <= '0;
            res         <= '0;
            cnt         <= '0;
            c           <= 1'b0;
            c_msb       <= 1'b0;
            bus.D       <= '0;
            bus.Bout    <= 1'b0;
            bus.Cin_msb <= 1'b0;
            bus.V       <= 1'b0;
            bus.Z       <= 1'b0;
            bus.N       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a <= bus.A;
                        sh_b <= ~bus.B;
                        c    <= ~bus.Bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    c    <= c_next;
                    res  <= d_final[WIDTH-1:1];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 2)) c_msb <= c_next;
                    if (last) begin
                        bus.D       <= d_final;
                        bus.Bout    <= ~c_next;
                        bus.Cin_msb <= c_msb;
                        bus.V       <= c_msb ^ c_next;
                        bus.Z       <= (d_final == '0);
                        bus.N       <= d_final[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed check of serial_subtractor against a cycle-level arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MASK  = (1 << WIDTH) - 1;
    localparam int unsigned HMASK = (1 << (WIDTH - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_seen = 0;
    bit   cmp_en = 1'b0;

    // model state: cycles until IDLE after an accept, pending and visible results
    int             remaining = 0;
    logic [WIDTH+4:0] pend  = '0;
    logic [WIDTH+4:0] m_res = '0;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {D, Bout, Cin_msb, V, Z, N} from plain integer arithmetic
    function automatic logic [WIDTH+4:0] golden(input int unsigned a, input int unsigned b,
                                                input int unsigned bin);
        int unsigned full, low, d, cout, cmsb;
        full = (a & MASK) + ((~b) & MASK) + (bin != 0 ? 0 : 1);
        low  = (a & HMASK) + ((~b) & HMASK) + (bin != 0 ? 0 : 1);
        d    = full & MASK;
        cout = (full >> WIDTH) & 1;
        cmsb = (low >> (WIDTH - 1)) & 1;
        return {WIDTH'(d), ~cout[0], cmsb[0], cmsb[0] ^ cout[0], d == 0, d[WIDTH-1]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            remaining = 0;
            m_res     = '0;
        end else if (remaining == 0) begin
            if (bus.start) begin
                pend      = golden(bus.A, bus.B, bus.Bin);
                remaining = WIDTH + 1;
            end
        end else begin
            remaining = remaining - 1;
            if (remaining == 1) m_res = pend;
        end
    end

    always @(negedge clk) begin
        logic [WIDTH+6:0] act, exp;
        if (cmp_en) begin
            act = {bus.busy, bus.done, bus.D, bus.Bout, bus.Cin_msb, bus.V, bus.Z, bus.N};
            exp = {remaining > 0, remaining == 1, m_res};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL outputs t=%0t: got %b expected %b", $time, act, exp);
            end
        end
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH+4:0] snap();
        return {bus.D, bus.Bout, bus.Cin_msb, bus.V, bus.Z, bus.N};
    endfunction

    // Launch one operation from IDLE, wait for done, return the result snapshot.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         output logic [WIDTH+4:0] r);
        int n, d0;
        d0 = done_seen;
        @(negedge clk);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 4 * WIDTH) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", n, WIDTH + 1);
        r = snap();
        @(negedge clk);
        check("done_pulses", done_seen - d0, 1);
    endtask

    initial begin
        logic [WIDTH+4:0] r;
        int d0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;

        check("pin_5m3", golden(5, 3, 0), {4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("pin_8m1", golden(8, 1, 0), {4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("pin_0m0b", golden(0, 0, 1), {4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("reset_outputs", {bus.busy, bus.done, snap()}, '0);

        do_op(4'd5, 4'd3, 1'b0, r);
        check("5m3_D", r[8:5], 2);
        check("5m3_flags", {r[4], r[2], r[1], r[0]}, 4'b0000);

        do_op(4'd3, 4'd5, 1'b0, r);
        check("3m5_D", r[8:5], 14);
        check("3m5_Bout_N_V", {r[4], r[0], r[2]}, 3'b110);

        do_op(4'd8, 4'd1, 1'b0, r);
        check("8m1_D", r[8:5], 7);
        check("8m1_Bout_Cmsb_V_N", {r[4], r[3], r[2], r[0]}, 4'b0010);

        do_op(4'd9, 4'd9, 1'b0, r);
        check("9m9_D_Z_Bout", {r[8:5], r[1], r[4]}, {4'd0, 1'b1, 1'b0});
        do_op(4'd0, 4'd0, 1'b1, r);
        check("0m0b_D_Bout_N", {r[8:5], r[4], r[0]}, {4'd15, 1'b1, 1'b1});

        // start held with changing operands through RUN and DONE
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd3; bus.Bin = 1'b0;
        r = '0;
        for (int i = 1; i <= WIDTH + 1; i++) begin
            @(negedge clk);
            check("hold_busy", bus.busy, 1'b1);
            if (bus.done === 1'b1) r = snap();
            if (i <= WIDTH) begin
                bus.A = 4'($urandom); bus.B = 4'($urandom); bus.Bin = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        check("hold_D", r[8:5], 2);
        @(negedge clk);

        // reset on the third RUN cycle
        d0 = done_seen;
        bus.start = 1'b1; bus.A = 4'd6; bus.B = 4'd2; bus.Bin = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrun_reset_outputs", {bus.busy, bus.done, snap()}, '0);
        repeat (WIDTH + 2) @(negedge clk);
        check("midrun_no_done", done_seen - d0, 0);
        do_op(4'd6, 4'd2, 1'b0, r);
        check("after_reset_D", r[8:5], 4);

        // randomized traffic, including held start and occasional reset
        for (int it = 0; it < 300; it++) begin
            int hold;
            hold = $urandom_range(1, 2 * WIDTH + 4);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.A = 4'($urandom); bus.B = 4'($urandom); bus.Bin = 1'($urandom);
                if ($urandom_range(0, 60) == 0) rst = 1'b1;
                else rst = 1'b0;
            end
            @(negedge clk);
            bus.start = 1'b0;
            rst = 1'b0;
            repeat ($urandom_range(0, WIDTH + 3)) @(negedge clk);
        end

        repeat (WIDTH + 3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
